// File: rtl/screen_update_engine_pkg.sv
`default_nettype none
// ============================================================================
// screen_update_engine_pkg - opcodes, FSM states and screen geometry helper
// Rev 1.0
// ============================================================================
package screen_update_engine_pkg;

  typedef enum logic [1:0] {
    OP_CHAR   = 2'd0,
    OP_CURSOR = 2'd1,
    OP_SCROLL = 2'd2,
    OP_FILL   = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  function automatic int screen_size(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/screen_update_engine_fifo.sv
`default_nettype none
// ============================================================================
// screen_update_engine_fifo - show-ahead synchronous FIFO with level output
// Rev 1.0
// ============================================================================
module screen_update_engine_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == DEPTH_W);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE_W;
        2'b01:   level_q <= level_q - ONE_W;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the level says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/screen_update_engine.sv
`default_nettype none
// ============================================================================
// screen_update_engine - queued display-command executor with wrapping FILL
// Rev 1.0
// ============================================================================
module screen_update_engine
  import screen_update_engine_pkg::*;
#(
  parameter int ROWS       = 24,
  parameter int COLS       = 80,
  parameter int ROW_BITS   = 5,
  parameter int COL_BITS   = 7,
  parameter int ADDR_BITS  = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [ADDR_BITS-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_data_i,
  input  logic [ADDR_BITS-1:0] cmd_count_i,
  output logic                 char_wen_o,
  output logic [ADDR_BITS-1:0] char_addr_o,
  output logic [7:0]           char_data_o,
  output logic                 cursor_wen_o,
  output logic [COL_BITS-1:0]  cursor_x_o,
  output logic [ROW_BITS-1:0]  cursor_y_o,
  output logic                 scroll_wen_o,
  output logic [ADDR_BITS-1:0] first_char_o,
  output logic                 busy_o,
  output logic                 drop_o,
  output logic [FIFO_AW:0]     fifo_level_o
);

  localparam int                   SCREEN_SIZE = screen_size(ROWS, COLS);
  localparam int                   FIFO_W      = 2 + 8 + 2*ADDR_BITS;
  localparam logic [ADDR_BITS:0]   SS_W        = (ADDR_BITS+1)'(SCREEN_SIZE);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(SCREEN_SIZE-1);
  localparam logic [ADDR_BITS:0]   ONE_W       = (ADDR_BITS+1)'(1);

  logic [FIFO_W-1:0]    fifo_wdata;
  logic [FIFO_W-1:0]    fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  op_e                  head_op;
  logic [7:0]           head_data;
  logic [ADDR_BITS-1:0] head_addr;
  logic [ADDR_BITS-1:0] head_count;
  logic                 head_in_range;

  state_e               state_q;
  logic [ADDR_BITS-1:0] fill_ptr_q;
  logic [ADDR_BITS:0]   fill_rem_q;
  logic [7:0]           fill_data_q;
  logic [ADDR_BITS:0]   fill_len_d;
  logic [ADDR_BITS-1:0] start_ptr_d;
  logic [ADDR_BITS-1:0] fill_ptr_d;

  assign fifo_wdata = {cmd_op_i, cmd_data_i, cmd_addr_i, cmd_count_i};

  screen_update_engine_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_valid_i),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign cmd_ready_o = !fifo_full;
  assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
  assign busy_o      = !fifo_empty || (state_q == ST_FILL);

  assign head_op       = op_e'(fifo_rdata[FIFO_W-1 -: 2]);
  assign head_data     = fifo_rdata[2*ADDR_BITS +: 8];
  assign head_addr     = fifo_rdata[ADDR_BITS +: ADDR_BITS];
  assign head_count    = fifo_rdata[0 +: ADDR_BITS];
  assign head_in_range = ({1'b0, head_addr} < SS_W);

  // A fill never needs to cover the screen more than once.
  assign fill_len_d  = ({1'b0, head_count} > SS_W) ? SS_W : {1'b0, head_count};
  assign start_ptr_d = (head_addr == LAST_ADDR) ? '0 : head_addr + 1'b1;
  assign fill_ptr_d  = (fill_ptr_q == LAST_ADDR) ? '0 : fill_ptr_q + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      fill_ptr_q   <= '0;
      fill_rem_q   <= '0;
      fill_data_q  <= '0;
      char_wen_o   <= 1'b0;
      char_addr_o  <= '0;
      char_data_o  <= '0;
      cursor_wen_o <= 1'b0;
      cursor_x_o   <= '0;
      cursor_y_o   <= '0;
      scroll_wen_o <= 1'b0;
      first_char_o <= '0;
      drop_o       <= 1'b0;
    end else begin
      char_wen_o   <= 1'b0;
      cursor_wen_o <= 1'b0;
      scroll_wen_o <= 1'b0;
      drop_o       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (head_op)
              OP_CHAR: begin
                if (head_in_range) begin
                  char_wen_o  <= 1'b1;
                  char_addr_o <= head_addr;
                  char_data_o <= head_data;
                end else begin
                  drop_o <= 1'b1;
                end
              end
              OP_CURSOR: begin
                cursor_wen_o <= 1'b1;
                cursor_x_o   <= head_addr[COL_BITS-1:0];
                cursor_y_o   <= head_data[ROW_BITS-1:0];
              end
              OP_SCROLL: begin
                if (head_in_range) begin
                  scroll_wen_o <= 1'b1;
                  first_char_o <= head_addr;
                end else begin
                  drop_o <= 1'b1;
                end
              end
              OP_FILL: begin
                if (!head_in_range) begin
                  drop_o <= 1'b1;
                end else if (fill_len_d != '0) begin
                  char_wen_o  <= 1'b1;
                  char_addr_o <= head_addr;
                  char_data_o <= head_data;
                  fill_data_q <= head_data;
                  fill_ptr_q  <= start_ptr_d;
                  fill_rem_q  <= fill_len_d - ONE_W;
                  if (fill_len_d > ONE_W) state_q <= ST_FILL;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FILL: begin
          char_wen_o  <= 1'b1;
          char_addr_o <= fill_ptr_q;
          char_data_o <= fill_data_q;
          fill_ptr_q  <= fill_ptr_d;
          fill_rem_q  <= fill_rem_q - ONE_W;
          if (fill_rem_q == ONE_W) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_screen_update_engine.sv
`default_nettype none
// ============================================================================
// tb_screen_update_engine - directed scoreboard bench for screen_update_engine
// Rev 1.0
// ============================================================================
module tb_screen_update_engine;

  localparam int SS = 1920;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = '0;
  logic [10:0] cmd_addr_i = '0;
  logic [7:0]  cmd_data_i = '0;
  logic [10:0] cmd_count_i = '0;
  logic        char_wen_o;
  logic [10:0] char_addr_o;
  logic [7:0]  char_data_o;
  logic        cursor_wen_o;
  logic [6:0]  cursor_x_o;
  logic [4:0]  cursor_y_o;
  logic        scroll_wen_o;
  logic [10:0] first_char_o;
  logic        busy_o;
  logic        drop_o;
  logic [3:0]  fifo_level_o;

  screen_update_engine dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .cmd_count_i  (cmd_count_i),
    .char_wen_o   (char_wen_o),
    .char_addr_o  (char_addr_o),
    .char_data_o  (char_data_o),
    .cursor_wen_o (cursor_wen_o),
    .cursor_x_o   (cursor_x_o),
    .cursor_y_o   (cursor_y_o),
    .scroll_wen_o (scroll_wen_o),
    .first_char_o (first_char_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int kind;  // 0 char, 1 cursor, 2 scroll, 3 drop
    int addr;
    int data;
  } ev_t;

  ev_t sb[$];
  int  evt_log[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Reference model of what each command should produce.
  task automatic expect_cmd(input int op, input int addr, input int data, input int count);
    int p;
    int n;
    case (op)
      0: if (addr < SS) sb.push_back(mk(0, addr, data)); else sb.push_back(mk(3, 0, 0));
      1: sb.push_back(mk(1, addr % 128, data % 32));
      2: if (addr < SS) sb.push_back(mk(2, addr, 0)); else sb.push_back(mk(3, 0, 0));
      default: begin
        if (addr >= SS) sb.push_back(mk(3, 0, 0));
        else begin
          n = (count > SS) ? SS : count;
          p = addr;
          for (int i = 0; i < n; i++) begin
            sb.push_back(mk(0, p, data));
            p = (p == SS - 1) ? 0 : p + 1;
          end
        end
      end
    endcase
  endtask

  always @(negedge clk_i) begin
    ev_t e;
    int  hot;
    int  kind;
    if (!reset_i && (char_wen_o || cursor_wen_o || scroll_wen_o || drop_o)) begin
      hot  = int'(char_wen_o) + int'(cursor_wen_o) + int'(scroll_wen_o) + int'(drop_o);
      kind = char_wen_o ? 0 : cursor_wen_o ? 1 : scroll_wen_o ? 2 : 3;
      check("strobe_onehot", hot, 1);
      evt_log.push_back(cyc);
      check("unexpected_strobe", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        if (e.kind == kind) begin
          case (kind)
            0: begin
              check("char_addr", {21'd0, char_addr_o}, e.addr);
              check("char_data", {24'd0, char_data_o}, e.data);
            end
            1: begin
              check("cursor_x", {25'd0, cursor_x_o}, e.addr);
              check("cursor_y", {27'd0, cursor_y_o}, e.data);
            end
            2: check("first_char", {21'd0, first_char_o}, e.addr);
            default: ;
          endcase
        end
      end
    end
  end

  task automatic send(input int op, input int addr, input int data, input int count);
    int guard = 0;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op[1:0];
    cmd_addr_i  = addr[10:0];
    cmd_data_i  = data[7:0];
    cmd_count_i = count[10:0];
    expect_cmd(op, addr, data, count);
    while (!cmd_ready_o && guard < 4000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 4000) check("accept_timeout", 1, 0);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int guard = 0;
    while ((sb.size() != 0 || busy_o) && guard < budget) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check(tag, {31'd0, guard < budget}, 1);
  endtask

  initial begin
    int acc;
    int base;
    int guard;

    // Reset state
    #3;
    check("rst_char_wen", {31'd0, char_wen_o}, 0);
    check("rst_char_addr", {21'd0, char_addr_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_level", {28'd0, fifo_level_o}, 0);
    check("rst_ready", {31'd0, cmd_ready_o}, 1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // 1: single CHAR, 2-clock latency, one pulse
    base = evt_log.size();
    send(0, 5, 8'h41, 0);
    acc = cyc;
    drain("t1_drain", 20);
    @(posedge clk_i); #1;
    check("t1_pulses", evt_log.size() - base, 1);
    if (evt_log.size() > base) check("t1_latency", evt_log[base], acc + 1);

    // 2: FILL wrapping past the end of the screen
    base = evt_log.size();
    send(3, 1915, 8'h20, 10);
    drain("t2_drain", 40);
    #1;
    check("t2_busy_after", {31'd0, busy_o}, 0);
    check("t2_writes", evt_log.size() - base, 10);
    if (evt_log.size() >= base + 10)
      check("t2_consecutive", evt_log[base + 9] - evt_log[base], 9);

    // 3: FIFO fills behind a full-screen FILL
    send(3, 0, 8'h2E, 1920);
    for (int i = 0; i < 8; i++) send(0, 100 + i, 8'h61 + i, 0);
    check("t3_level_full", {28'd0, fifo_level_o}, 8);
    check("t3_ready_low", {31'd0, cmd_ready_o}, 0);
    check("t3_busy", {31'd0, busy_o}, 1);
    send(0, 108, 8'h69, 0);
    drain("t3_drain", 5000);

    // 4: out-of-range commands and empty FILL
    base = evt_log.size();
    send(0, 1920, 8'h55, 0);
    send(2, 2000, 0, 0);
    send(3, 0, 8'h20, 0);
    drain("t4_drain", 20);
    repeat (3) @(posedge clk_i);
    #1;
    check("t4_events", evt_log.size() - base, 2);
    check("t4_idle", {31'd0, busy_o}, 0);

    // 5: reset in the middle of a FILL
    base = evt_log.size();
    send(3, 100, 8'h2A, 50);
    guard = 0;
    while (evt_log.size() < base + 3 && guard < 50) begin
      @(posedge clk_i);
      guard++;
    end
    check("t5_wait", {31'd0, guard < 50}, 1);
    #1;
    reset_i = 1'b1;
    #1;
    check("t5_char_wen", {31'd0, char_wen_o}, 0);
    check("t5_char_addr", {21'd0, char_addr_o}, 0);
    check("t5_char_data", {24'd0, char_data_o}, 0);
    check("t5_busy", {31'd0, busy_o}, 0);
    check("t5_level", {28'd0, fifo_level_o}, 0);
    check("t5_ready", {31'd0, cmd_ready_o}, 1);
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("t5_no_more_writes", evt_log.size() - base, 3);

    // 6: CURSOR then SCROLL in back-to-back cycles
    base = evt_log.size();
    send(1, 79, 23, 0);
    send(2, 80, 0, 0);
    drain("t6_drain", 20);
    @(posedge clk_i); #1;
    check("t6_events", evt_log.size() - base, 2);
    if (evt_log.size() >= base + 2)
      check("t6_adjacent", evt_log[base + 1] - evt_log[base], 1);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
